dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
Two-requester arbiter for the 8-bit data memory. It shares the single dmem port between the CPU datapath and a host/debug port used for memory load and inspection. The CPU has priority, and the host is protected from starvation by a wait counter and a burst limit. The block sits between the CPU's dmem-facing signals and the dmem instance. It produces a stall signal that the CPU clock-gating logic ORs with HLT.

Parameters:
ADDR_W, 8, address width (matches the instruction-register operand field)
DATA_W, 8, data width (matches the R register and dmem word)
HOST_WAIT_MAX, 4, consecutive denied host-request cycles before the host is force-granted (1..15)
HOST_MAX_BURST, 4, maximum consecutive host grant cycles while cpu_req is pending (1..15)

Ports:
clk  in  1  system clock; all state on the rising edge
reset_arb  in  1  synchronous, active-high reset
cpu_req  in  1  CPU access request; held until cpu_gnt is seen
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  ADDR_W  CPU address
cpu_wdata  in  DATA_W  CPU write data (the R value)
cpu_gnt  out  1  registered; CPU owns the memory this cycle
cpu_stall  out  1  cpu_req & ~cpu_gnt (combinational)
cpu_rdata  out  DATA_W  registered read data
cpu_rvalid  out  1  one-cycle pulse; cpu_rdata is valid
host_req  in  1  host access request; held until host_gnt is seen
host_we  in  1  1 = write, 0 = read
host_addr  in  ADDR_W  host address
host_wdata  in  DATA_W  host write data
host_gnt  out  1  registered; host owns the memory this cycle
host_rdata  out  DATA_W  registered read data
host_rvalid  out  1  one-cycle pulse; host_rdata is valid
mem_addr  out  ADDR_W  to dmem address
mem_wdata  out  DATA_W  to dmem write value
mem_we  out  1  to dmem write enable (REDMEM)
mem_rdata  in  DATA_W  from dmem; combinational read of mem_addr

Behaviour:
- Reset (synchronous, active-high): state=IDLE, wait_cnt=0, burst_cnt=0, all gnt/rvalid=0, rdata regs=0. A reset asserted mid-access wins: the grant drops on the next edge, and no rvalid is produced for the aborted access.
- States: IDLE, CPU, HOST, one-hot encoded. cpu_gnt=(state==CPU); host_gnt=(state==HOST).
- Memory mux (combinational from state):
  - CPU: mem_* driven by cpu_addr, cpu_wdata, cpu_we.
  - HOST: mem_* driven by host_addr, host_wdata, host_we.
  - IDLE: mem_addr=0, mem_wdata=0, mem_we=0.
- One access per granted cycle. A read captures mem_rdata into the owner's rdata register at the end of that cycle. The owner's rvalid pulses for 1 cycle on the following cycle. Read latency is 1 cycle after gnt. Writes produce no rvalid.
- Next state, evaluated every cycle:
  - no requests -> IDLE
  - cpu_req only -> CPU
  - host_req only -> HOST
  - both requesting:
    - state==HOST and burst_cnt<HOST_MAX_BURST -> HOST
    - else wait_cnt>=HOST_WAIT_MAX -> HOST
    - else -> CPU
- wait_cnt:
  - increments while host_req & ~host_gnt, saturating at HOST_WAIT_MAX
  - cleared on any host_gnt cycle
  - cleared when host_req=0
- burst_cnt:
  - loads 1 on the edge entering HOST
  - increments (saturating) on each additional HOST cycle
  - cleared outside HOST
- Burst limit: when both requesters are waiting, a host burst ends after exactly HOST_MAX_BURST grant cycles. The CPU then gets at least 1 cycle. The host is re-granted only after wait_cnt again reaches HOST_WAIT_MAX.
- Requester dropping its req while granted: the grant continues for that cycle. The grant is removed on the next edge, with no extra access.
- Requester inputs are sampled only in granted cycles. A requester changing addr/data while not granted has no effect.
- Guarantee: cpu_gnt and host_gnt are never both 1.
- Guarantee: mem_we=0 whenever neither grant is asserted.
- Target: 120–250 lines of RTL.

Test Plan:
- Reset, then cpu_req=1, cpu_we=0, cpu_addr=0x10, mem model [0x10]=0xA5 -> cpu_stall=1 for 1 cycle, then cpu_gnt=1, mem_addr=0x10; next cycle cpu_rvalid=1, cpu_rdata=0xA5.
- host_req=1, host_we=1, host_addr=0x22, host_wdata=0x5C with CPU idle -> host_gnt next cycle, mem_we=1 for exactly 1 cycle if the request then drops; a later host read of 0x22 returns 0x5C via host_rvalid.
- cpu_req held continuously, host_req asserted at cycle T (defaults 4/4):
  - host denied for T..T+3 while wait_cnt reaches 4
  - host_gnt for 4 cycles, then cpu_gnt
  - cpu_stall high exactly during host grants
  - never both grants high
- Both requesters held for 40 cycles -> a repeating pattern of 4 host grants followed by CPU grants. Per 40 cycles: cpu_gnt count >= 20, host_gnt count >= 16.
- reset_arb pulsed during a host read grant -> host_gnt=0 and host_rvalid=0 on the following cycle, wait_cnt=0, state IDLE; the next cpu_req is granted after 1 cycle.
- HOST_WAIT_MAX=1, HOST_MAX_BURST=1, both requesting -> strict alternation CPU, HOST, CPU, HOST after the first denied host cycle.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for the 8-bit data memory port: CPU has priority, the host
// is protected from starvation by a wait counter and a bounded grant burst.
module dmem_arbiter #(
    parameter int ADDR_W         = 8,
    parameter int DATA_W         = 8,
    parameter int HOST_WAIT_MAX  = 4,
    parameter int HOST_MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              reset_arb,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_stall,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_rvalid,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_gnt,
    output logic [DATA_W-1:0] host_rdata,
    output logic              host_rvalid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [3:0] WAIT_MAX_C  = 4'(HOST_WAIT_MAX);
    localparam logic [3:0] BURST_MAX_C = 4'(HOST_MAX_BURST);

    typedef enum logic [2:0] {
        ST_IDLE = 3'b001,
        ST_CPU  = 3'b010,
        ST_HOST = 3'b100
    } state_t;

    state_t            state_reg, state_next;
    logic [3:0]        wait_cnt_reg, wait_cnt_next, wait_inc;
    logic [3:0]        burst_cnt_reg, burst_cnt_next;
    logic              host_denied;
    logic [DATA_W-1:0] cpu_rdata_reg, host_rdata_reg;
    logic              cpu_rvalid_reg, host_rvalid_reg;

    assign cpu_gnt     = (state_reg == ST_CPU);
    assign host_gnt    = (state_reg == ST_HOST);
    assign cpu_stall   = cpu_req & ~cpu_gnt;
    assign cpu_rdata   = cpu_rdata_reg;
    assign host_rdata  = host_rdata_reg;
    assign cpu_rvalid  = cpu_rvalid_reg;
    assign host_rvalid = host_rvalid_reg;

    assign host_denied = host_req & ~host_gnt;

    // The wait count includes the current denied cycle, so the host is granted on
    // the edge right after its HOST_WAIT_MAX-th consecutive denied cycle.
    always_comb begin
        wait_inc = wait_cnt_reg;
        if (host_denied && (wait_cnt_reg < WAIT_MAX_C)) begin
            wait_inc = wait_cnt_reg + 4'd1;
        end
    end

    always_comb begin
        state_next = ST_IDLE;
        if (cpu_req && host_req) begin
            if ((state_reg == ST_HOST) && (burst_cnt_reg < BURST_MAX_C)) begin
                state_next = ST_HOST;
            end else if (wait_inc >= WAIT_MAX_C) begin
                state_next = ST_HOST;
            end else begin
                state_next = ST_CPU;
            end
        end else if (cpu_req) begin
            state_next = ST_CPU;
        end else if (host_req) begin
            state_next = ST_HOST;
        end
    end

    always_comb begin
        wait_cnt_next = wait_inc;
        if (!host_req || host_gnt || (state_next == ST_HOST)) begin
            wait_cnt_next = 4'd0;
        end
    end

    always_comb begin
        burst_cnt_next = 4'd0;
        if (state_next == ST_HOST) begin
            if (state_reg != ST_HOST) begin
                burst_cnt_next = 4'd1;
            end else if (burst_cnt_reg != 4'hF) begin
                burst_cnt_next = burst_cnt_reg + 4'd1;
            end else begin
                burst_cnt_next = burst_cnt_reg;
            end
        end
    end

    // Only the owner's inputs reach the memory; an idle port never writes.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        if (cpu_gnt) begin
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            mem_we    = cpu_we;
        end else if (host_gnt) begin
            mem_addr  = host_addr;
            mem_wdata = host_wdata;
            mem_we    = host_we;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_arb) begin
            state_reg       <= ST_IDLE;
            wait_cnt_reg    <= 4'd0;
            burst_cnt_reg   <= 4'd0;
            cpu_rdata_reg   <= '0;
            host_rdata_reg  <= '0;
            cpu_rvalid_reg  <= 1'b0;
            host_rvalid_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            wait_cnt_reg    <= wait_cnt_next;
            burst_cnt_reg   <= burst_cnt_next;
            cpu_rvalid_reg  <= cpu_gnt & ~cpu_we;
            host_rvalid_reg <= host_gnt & ~host_we;
            if (cpu_gnt && !cpu_we) begin
                cpu_rdata_reg <= mem_rdata;
            end
            if (host_gnt && !host_we) begin
                host_rdata_reg <= mem_rdata;
            end
        end
    end

endmodule
